// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: one-hot state encoding,
// default timing constants and the state-to-strobe decode.
package debounce_pkg;

  // 10 ms debounce and 0.25 s auto-repeat at a 100 MHz board clock.
  localparam int N_DEB_DEFAULT = 1000000;
  localparam int N_REP_DEFAULT = 25000000;
  localparam int CNT_W_DEFAULT = 25;

  typedef enum logic [5:0] {
    INI     = 6'b000001,
    WQ      = 6'b000010,
    SCEN_ST = 6'b000100,
    HOLD    = 6'b001000,
    MCEN_ST = 6'b010000,
    WFCR    = 6'b100000
  } state_t;

  typedef struct packed {
    logic dpb;
    logic scen;
    logic mcen;
    logic ccen;
  } strobes_t;

  function automatic strobes_t decode_strobes(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      SCEN_ST: o = '{dpb: 1'b1, scen: 1'b1, mcen: 1'b1, ccen: 1'b1};
      HOLD:    o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b0, ccen: 1'b1};
      MCEN_ST: o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b1, ccen: 1'b1};
      WFCR:    o = '{dpb: 1'b1, scen: 1'b0, mcen: 1'b0, ccen: 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low clear.
// Two cycles of latency from d to q; no handshake.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debouncer_pulser.sv
// Push-button conditioner: sync, debounce press/release, emit level, press pulse,
// auto-repeat pulse and hold enable; all outputs registered from the next state.
module debouncer_pulser
  import debounce_pkg::*;
#(
  parameter int N_DEB = N_DEB_DEFAULT,
  parameter int N_REP = N_REP_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN,
  output logic CCEN
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(N_DEB - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(N_REP - 1);

  logic             pb_s;
  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  strobes_t         strobes_q;

  sync_2ff u_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (PB),
    .q     (pb_s)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= INI;
      cnt_q     <= '0;
      strobes_q <= '0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      strobes_q <= decode_strobes(state_nxt);
    end
  end

  // Terminal compares are tested before incrementing, so the counter never wraps.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    case (state_q)
      INI: begin
        cnt_nxt = '0;
        if (pb_s) state_nxt = WQ;
      end
      WQ: begin
        if (!pb_s) begin
          state_nxt = INI;
          cnt_nxt   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_nxt = SCEN_ST;
          cnt_nxt   = '0;
        end
      end
      SCEN_ST: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      HOLD: begin
        // Release wins over a repeat that would fire in the same cycle.
        if (!pb_s) begin
          state_nxt = WFCR;
          cnt_nxt   = '0;
        end else if (cnt_q == REP_LAST) begin
          state_nxt = MCEN_ST;
          cnt_nxt   = '0;
        end
      end
      MCEN_ST: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      WFCR: begin
        if (pb_s) begin
          cnt_nxt = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_nxt = INI;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INI;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign DPB  = strobes_q.dpb;
  assign SCEN = strobes_q.scen;
  assign MCEN = strobes_q.mcen;
  assign CCEN = strobes_q.ccen;

endmodule

// File: tb/tb_debouncer_pulser.sv
// Self-checking bench for debouncer_pulser with short debounce/repeat counts.
module tb_debouncer_pulser;

  localparam int N_DEB = 4;
  localparam int N_REP = 8;
  localparam int CNT_W = 5;
  localparam int P     = N_REP + 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic PB = 1'b0;
  logic DPB, SCEN, MCEN, CCEN;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference: button behaviour described by run lengths and time since press.
  bit m_s1, m_s2, m_held, m_rel;
  int m_run, m_lrun, m_age;

  debouncer_pulser #(.N_DEB(N_DEB), .N_REP(N_REP), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PB(PB),
    .DPB(DPB), .SCEN(SCEN), .MCEN(MCEN), .CCEN(CCEN)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_held = 0; m_rel = 0;
    m_run = 0; m_lrun = 0; m_age = 0;
  endtask

  task automatic model_edge(input bit pb_pre);
    bit smp;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = pb_pre;
    if (!m_held) begin
      m_run = smp ? m_run + 1 : 0;
      if (m_run == N_DEB + 1) begin
        m_held = 1; m_rel = 0; m_age = 0; m_run = 0;
      end
    end else if (m_rel) begin
      m_lrun = smp ? 0 : m_lrun + 1;
      if (m_lrun == N_DEB) begin
        m_held = 0; m_rel = 0; m_run = 0;
      end
    end else if (m_age % P == 0) begin
      m_age++;  // pulse cycles do not look at the button
    end else if (!smp) begin
      m_rel = 1; m_lrun = 0;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [3:0] model_out();
    logic act;
    act = m_held && !m_rel;
    return {m_held, act && (m_age == 0), act && (m_age % P == 0), act};
  endfunction

  task automatic check(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick(input string tag);
    bit pb_pre;
    pb_pre = PB;
    @(posedge Clk);
    model_edge(pb_pre);
    #1;
    check(tag, int'({DPB, SCEN, MCEN, CCEN}), int'(model_out()));
  endtask

  task automatic idle();
    PB = 1'b0;
    repeat (14) tick("idle");
  endtask

  initial begin
    int scen_q[$];
    int mcen_q[$];
    int ccen_first, ccen_last, dpb_fall, r;
    bit any_out, bad;

    // Reset state
    model_reset();
    #1;
    check("reset_state", int'({DPB, SCEN, MCEN, CCEN}), 0);
    #3 Reset_n = 1'b1;
    idle();

    // Clean press held 40 edges, then clean release captured at edge 40
    ccen_first = -1; ccen_last = -1; dpb_fall = -1;
    for (int i = 0; i < 60; i++) begin
      PB = (i < 40);
      tick("clean_press");
      if (SCEN) scen_q.push_back(i);
      if (MCEN) mcen_q.push_back(i);
      if (CCEN && ccen_first < 0) ccen_first = i;
      if (CCEN) ccen_last = i;
      if (!DPB && ccen_first >= 0 && dpb_fall < 0) dpb_fall = i;
    end
    check("scen_count", scen_q.size(), 1);
    check("scen_edge", scen_q.size() > 0 ? scen_q[0] : -1, N_DEB + 2);
    check("mcen_count", mcen_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check("mcen_edge", mcen_q.size() > k ? mcen_q[k] : -1, N_DEB + 2 + k * P);
    check("ccen_first", ccen_first, N_DEB + 2);
    check("ccen_last", ccen_last, 41);
    check("dpb_fall", dpb_fall, 40 + N_DEB + 2);
    idle();

    // Press bounce: high 2, low 1, repeated
    any_out = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int j = 0; j < 3; j++) begin
        PB = (j != 2);
        tick("press_bounce");
        if (DPB || SCEN || MCEN || CCEN) any_out = 1;
      end
    end
    idle();
    check("bounce_quiet", int'(any_out), 0);

    // Release bounce: low captured at 20,21, high at 22, low from 23 on
    scen_q.delete();
    dpb_fall = -1; bad = 0; r = 23;
    for (int i = 0; i < 40; i++) begin
      PB = (i < 20) || (i == 22);
      tick("release_bounce");
      if (SCEN) scen_q.push_back(i);
      if (i >= 23 && i < r + N_DEB && (!DPB || CCEN)) bad = 1;
      if (!DPB && i > 20 && dpb_fall < 0) dpb_fall = i;
    end
    check("rb_one_scen", scen_q.size(), 1);
    check("rb_wfcr_level", int'(bad), 0);
    check("rb_dpb_fall", int'(dpb_fall >= r + N_DEB + 1 && dpb_fall <= r + N_DEB + 2), 1);
    idle();

    // Release whose first low sample lands in the repeat-pulse cycle
    scen_q.delete(); mcen_q.delete();
    ccen_last = -1;
    for (int i = 0; i < 30; i++) begin
      PB = (i < 14);
      tick("rel_in_mcen");
      if (SCEN) scen_q.push_back(i);
      if (MCEN) mcen_q.push_back(i);
      if (CCEN) ccen_last = i;
    end
    check("rm_scen", scen_q.size(), 1);
    check("rm_mcen_count", mcen_q.size(), 2);
    check("rm_mcen_rep", mcen_q.size() > 1 ? mcen_q[1] : -1, N_DEB + 2 + P);
    check("rm_ccen_last", ccen_last, N_DEB + 3 + P);
    idle();

    // Asynchronous reset in the middle of a hold
    PB = 1'b1;
    repeat (10) tick("pre_reset");
    check("hold_before_reset", int'(CCEN), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("reset_async", int'({DPB, SCEN, MCEN, CCEN}), 0);
    model_reset();
    #1 Reset_n = 1'b1;
    scen_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick("after_reset");
      if (SCEN) scen_q.push_back(i);
    end
    check("reset_relatency", scen_q.size() > 0 ? scen_q[0] : -1, N_DEB + 2);
    idle();

    // Randomised button activity
    for (int seg = 0; seg < 120; seg++) begin
      PB = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, N_DEB + N_REP + 4)) tick("random");
    end
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
